cmd_sequencer: RTL and testbench

- Upstream stage of the training controller. Buffers 32-bit operation words from the host in a small FIFO and issues each one on `operation`, holding it for exactly as many cycles as that opcode needs.
- Streams serial page-write data onto `in_data` and collects serial page-read data from `out_data`.
- Gates the controller's `enable` to stall when the write stream runs dry. Inserts idle gaps so every opcode-1 issue presents a fresh rising edge.

---
 rtl/cmd_sequencer_pkg.sv | 25 ++
 rtl/cmd_sequencer_if.sv | 24 ++
 rtl/cmd_sequencer_fifo.sv | 52 +++++
 rtl/cmd_sequencer.sv | 149 ++++++++++++++
 tb/tb_cmd_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_sequencer_pkg.sv
// Shared definitions for the command sequencer: opcode values, operation-word
// field offsets and the issue FSM state type.
package cmd_sequencer_pkg;

  localparam logic [3:0] OP_IDLE   = 4'd0;
  localparam logic [3:0] OP_MATMUL = 4'd1;
  localparam logic [3:0] OP_WRITE  = 4'd2;
  localparam logic [3:0] OP_READ   = 4'd3;

  // Operation word layout: {..., chunk1, opcode}
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned CHUNK1_LSB = 4;
  localparam int unsigned OPCODE_W   = CHUNK1_LSB - OPCODE_LSB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } state_e;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] word);
    return word[OPCODE_LSB +: OPCODE_W];
  endfunction

endpackage

// File: rtl/cmd_sequencer_if.sv
// Host-side bundle of the command sequencer: operation-word push, serial
// write stream in, serial read stream out.
interface cmd_sequencer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;

  modport master (
    output cmd_valid, cmd_data, wr_valid, wr_data,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_data, wr_valid, wr_data,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/cmd_sequencer_fifo.sv
// Synchronous FIFO for operation words with registered wrap-bit pointers.
// A push while full is accepted only when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !reset_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Command sequencer: queues host operation words and issues each to the
// controller for its opcode-specific hold time, streaming page data in/out.
// Optional performance counters are enabled with CMD_SEQ_PERF_EN.
module cmd_sequencer
  import cmd_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PAGE_WORDS = 64,
  parameter int unsigned MM_CYCLES  = 160,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  cmd_sequencer_if.slave    host,
  output logic [31:0]       operation_o,
  output logic [31:0]       in_data_o,
  input  logic [31:0]       out_data_i,
  output logic              ctrl_enable_o,
  output logic              busy_o
`ifdef CMD_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_busy_o,
  output logic [31:0]       perf_stall_o
`endif
);

  state_e            state_q, state_d;
  logic [31:0]       cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [READ_LAT-1:0] tag_q;
  logic              rd_valid_q;
  logic [31:0]       rd_data_q;

  logic              fifo_push, fifo_pop, pop_req;
  logic              fifo_full, fifo_empty;
  logic [31:0]       fifo_dout;
  logic [3:0]        cur_op;
  logic              in_issue, wr_stream, legal_op, tag_in;

  function automatic logic [CNT_W-1:0] hold_count(input logic [3:0] op);
    case (op)
      OP_IDLE:   return CNT_W'(1);
      OP_MATMUL: return CNT_W'(MM_CYCLES);
      OP_WRITE:  return CNT_W'(PAGE_WORDS);
      OP_READ:   return CNT_W'(PAGE_WORDS + READ_LAT);
      default:   return CNT_W'(1);
    endcase
  endfunction

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (host.cmd_data),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cur_op    = opcode_of(cmd_q);
  assign legal_op  = cur_op inside {OP_MATMUL, OP_WRITE, OP_READ};
  assign in_issue  = (state_q == ST_ISSUE);
  assign wr_stream = in_issue && (cur_op == OP_WRITE);
  // Tag only the first PAGE_WORDS issue cycles; the last READ_LAT just drain.
  assign tag_in    = in_issue && (cur_op == OP_READ) && (cnt_q > CNT_W'(READ_LAT));

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    pop_req = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (!fifo_empty) begin
          pop_req = 1'b1;
          cmd_d   = fifo_dout;
          cnt_d   = hold_count(opcode_of(fifo_dout));
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if ((cur_op != OP_WRITE) || host.wr_valid) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_GAP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
  assign fifo_pop       = pop_req && enable_i && !reset_i;
  assign host.cmd_ready = reset_i || !fifo_full || fifo_pop;
  assign fifo_push      = host.cmd_valid && host.cmd_ready && enable_i && !reset_i;

  assign operation_o   = (!reset_i && in_issue && legal_op) ? cmd_q : '0;
  assign in_data_o     = (!reset_i && wr_stream) ? host.wr_data : '0;
  assign host.wr_ready = !reset_i && enable_i && wr_stream && host.wr_valid;
  assign ctrl_enable_o = !reset_i && enable_i && !(wr_stream && !host.wr_valid);
  assign busy_o        = !reset_i && (!fifo_empty || (state_q != ST_IDLE));
  assign host.rd_valid = !reset_i && enable_i && rd_valid_q;
  assign host.rd_data  = reset_i ? '0 : rd_data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      cnt_q      <= '0;
      tag_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (enable_i) begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      tag_q[0]   <= tag_in;
      for (int unsigned i = 1; i < READ_LAT; i++) tag_q[i] <= tag_q[i-1];
      rd_valid_q <= tag_q[READ_LAT-1];
      if (tag_q[READ_LAT-1]) rd_data_q <= out_data_i;
    end
  end

`ifdef CMD_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_stall_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else if (enable_i) begin
      if (busy_o && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 1'b1;
      if (wr_stream && !host.wr_valid && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_busy_o  = perf_busy_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: per-cycle output log plus one task per
// scenario comparing against hand-derived cycle positions and values.
module tb_cmd_sequencer;

  localparam int NLOG = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] operation, in_data, out_data;
  logic        ctrl_enable, busy;
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;

  logic [31:0] op_log  [NLOG];
  logic [31:0] ind_log [NLOG];
  logic [31:0] rdd_log [NLOG];
  logic        ce_log  [NLOG];
  logic        wrr_log [NLOG];
  logic        rdv_log [NLOG];
  logic        busy_log[NLOG];

  cmd_sequencer_if hif();

`ifdef CMD_SEQ_PERF_EN
  logic [31:0] perf_busy, perf_stall;
`endif

  cmd_sequencer #(
    .FIFO_DEPTH (4),
    .PAGE_WORDS (64),
    .MM_CYCLES  (160),
    .READ_LAT   (1),
    .CNT_W      (16)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .enable_i      (enable),
    .host          (hif),
    .operation_o   (operation),
    .in_data_o     (in_data),
    .out_data_i    (out_data),
    .ctrl_enable_o (ctrl_enable),
    .busy_o        (busy)
`ifdef CMD_SEQ_PERF_EN
    ,
    .perf_busy_o   (perf_busy),
    .perf_stall_o  (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller stub: read data is the current cycle index.
  assign out_data = 32'(cyc);

  always @(negedge clk) begin
    if (cyc < NLOG) begin
      op_log[cyc]   = operation;
      ind_log[cyc]  = in_data;
      rdd_log[cyc]  = hif.rd_data;
      ce_log[cyc]   = ctrl_enable;
      wrr_log[cyc]  = hif.wr_ready;
      rdv_log[cyc]  = hif.rd_valid;
      busy_log[cyc] = busy;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [31:0] d, output int acc);
    acc = -1;
    tick();
    hif.cmd_valid = 1'b1;
    hif.cmd_data  = d;
    #1;
    for (int i = 0; i < 2000; i++) begin
      if (hif.cmd_ready === 1'b1) begin
        acc = cyc;
        break;
      end
      tick();
      #1;
    end
    tick();
    hif.cmd_valid = 1'b0;
    checks++;
    if (acc < 0) $display("FAIL push_accept: word %h never accepted, required accept within 2000 cycles", d);
    else passes++;
  endtask

  task automatic wait_idle(input int limit);
    int ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      #1;
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (ok == 0) $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, limit);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    hif.cmd_valid = 1'b1;
    hif.cmd_data  = 32'h0000_0011;
    hif.wr_valid  = 1'b1;
    hif.wr_data   = 32'h5555_AAAA;
    tick();
    tick();
    #1;
    checks++; if (operation !== 32'h0)    $display("FAIL rst_operation: got %h required 0", operation);   else passes++;
    checks++; if (in_data !== 32'h0)      $display("FAIL rst_in_data: got %h required 0", in_data);       else passes++;
    checks++; if (hif.rd_valid !== 1'b0)  $display("FAIL rst_rd_valid: got %b required 0", hif.rd_valid); else passes++;
    checks++; if (hif.rd_data !== 32'h0)  $display("FAIL rst_rd_data: got %h required 0", hif.rd_data);   else passes++;
    checks++; if (hif.cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b required 1", hif.cmd_ready); else passes++;
    checks++; if (hif.wr_ready !== 1'b0)  $display("FAIL rst_wr_ready: got %b required 0", hif.wr_ready); else passes++;
    checks++; if (busy !== 1'b0)          $display("FAIL rst_busy: got %b required 0", busy);             else passes++;
    checks++; if (ctrl_enable !== 1'b0)   $display("FAIL rst_ctrl_enable: got %b required 0", ctrl_enable); else passes++;
    tick();
    reset = 1'b0;
    hif.cmd_valid = 1'b0;
    hif.wr_valid  = 1'b0;
    hif.wr_data   = 32'h0;
    tick();
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rst_push_ignored: busy=%b required 0", busy); else passes++;
  endtask

  task automatic test_matmul();
    int a, b, i, na, nb;
    logic [31:0] wa, wb;
    wa = 32'h0000_1211;
    wb = 32'h0000_3451;
    push_cmd(wa, a);
    push_cmd(wb, b);
    wait_idle(600);
    i = a;
    while (i < NLOG - 2 && op_log[i] !== wa && i < a + 10) i++;
    na = 0;
    while (i < NLOG - 2 && op_log[i] === wa) begin na++; i++; end
    checks++; if (na != 160) $display("FAIL mm_hold_a: got %0d cycles required 160", na); else passes++;
    checks++; if (op_log[i] !== 32'h0) $display("FAIL mm_gap: got %h required 0", op_log[i]); else passes++;
    checks++; if (op_log[i+1] !== wb) $display("FAIL mm_second_issue: got %h required %h", op_log[i+1], wb); else passes++;
    i = i + 1;
    nb = 0;
    while (i < NLOG - 1 && op_log[i] === wb) begin nb++; i++; end
    checks++; if (nb != 160) $display("FAIL mm_hold_b: got %0d cycles required 160", nb); else passes++;
  endtask

  task automatic test_enable_freeze();
    int a, bad, n;
    logic [31:0] we;
    we = 32'h0000_0911;
    push_cmd(we, a);
    for (int i = 0; i < 10; i++) begin
      if (operation === we) break;
      tick();
      #1;
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      enable = 1'b0;
      #1;
      if (ctrl_enable !== 1'b0 || hif.wr_ready !== 1'b0 || operation !== we) bad++;
    end
    tick();
    enable = 1'b1;
    wait_idle(400);
    n = 0;
    for (int i = a; i < cyc && i < NLOG; i++) if (op_log[i] === we) n++;
    checks++; if (bad != 0) $display("FAIL en_frozen_outputs: got %0d bad cycles required 0", bad); else passes++;
    checks++; if (n != 170) $display("FAIL en_hold_extended: got %0d cycles required 170", n); else passes++;
  endtask

  task automatic test_write();
    int a, n, stall, bad, nhold, nce, nwr, stray;
    logic [31:0] ww;
    ww = 32'h0000_0002;
    push_cmd(ww, a);
    n = 0;
    stall = 0;
    bad = 0;
    for (int i = 0; i < 300 && n < 64; i++) begin
      tick();
      if (n == 10 && stall < 5) begin
        hif.wr_valid = 1'b0;
        stall++;
      end else begin
        hif.wr_valid = 1'b1;
        hif.wr_data  = 32'hA000_0000 + 32'(n);
      end
      #1;
      if (hif.wr_ready === 1'b1) begin
        if (in_data !== 32'hA000_0000 + 32'(n)) bad++;
        n++;
      end
    end
    tick();
    hif.wr_valid = 1'b0;
    wait_idle(200);
    nhold = 0; nce = 0; nwr = 0; stray = 0;
    for (int i = a; i < cyc && i < NLOG; i++) begin
      if (op_log[i] === ww) begin
        nhold++;
        if (ce_log[i] === 1'b0) nce++;
      end else if (ind_log[i] !== 32'h0) stray++;
      if (wrr_log[i] === 1'b1) nwr++;
    end
    checks++; if (nhold != 69) $display("FAIL wr_hold: got %0d cycles required 69", nhold); else passes++;
    checks++; if (nce != 5) $display("FAIL wr_ctrl_enable_low: got %0d cycles required 5", nce); else passes++;
    checks++; if (nwr != 64) $display("FAIL wr_ready_pulses: got %0d required 64", nwr); else passes++;
    checks++; if (bad != 0) $display("FAIL wr_in_data: got %0d bad words required 0", bad); else passes++;
    checks++; if (stray != 0) $display("FAIL wr_in_data_idle: got %0d nonzero cycles required 0", stray); else passes++;
  endtask

  task automatic test_read();
    int a, ts, nhold, nrd, first, bad;
    logic [31:0] wr;
    wr = 32'h0000_0003;
    push_cmd(wr, a);
    wait_idle(200);
    ts = -1; first = -1; nhold = 0; nrd = 0; bad = 0;
    for (int i = a; i < cyc && i < NLOG; i++) begin
      if (op_log[i] === wr) begin
        nhold++;
        if (ts < 0) ts = i;
      end
      if (rdv_log[i] === 1'b1) begin
        nrd++;
        if (first < 0) first = i;
      end
    end
    checks++; if (nhold != 65) $display("FAIL rd_hold: got %0d cycles required 65", nhold); else passes++;
    checks++; if (nrd != 64) $display("FAIL rd_valid_pulses: got %0d required 64", nrd); else passes++;
    checks++; if (first != ts + 2) $display("FAIL rd_first_latency: got cycle %0d required %0d", first, ts + 2); else passes++;
    for (int k = 0; k < 64; k++) begin
      if (ts < 0 || ts + 2 + k >= NLOG) begin bad++; continue; end
      if (rdv_log[ts+2+k] !== 1'b1 || rdd_log[ts+2+k] !== 32'(ts + 1 + k)) bad++;
    end
    checks++; if (bad != 0) $display("FAIL rd_data_sequence: got %0d bad words required 0", bad); else passes++;
  endtask

  task automatic test_fifo_full();
    logic [31:0] c [6];
    logic [31:0] seq [8];
    int a0, acc, a5, ns;
    c[0] = 32'h0000_0111; c[1] = 32'h0000_0211; c[2] = 32'h0000_0311;
    c[3] = 32'h0000_0411; c[4] = 32'h0000_0511; c[5] = 32'h0000_0611;
    push_cmd(c[0], a0);
    for (int k = 1; k < 5; k++) push_cmd(c[k], acc);
    tick();
    hif.cmd_valid = 1'b1;
    hif.cmd_data  = c[5];
    #1;
    checks++; if (hif.cmd_ready !== 1'b0) $display("FAIL fifo_full_ready: got %b required 0", hif.cmd_ready); else passes++;
    a5 = -1;
    for (int i = 0; i < 400; i++) begin
      tick();
      #1;
      if (hif.cmd_ready === 1'b1) begin
        a5 = cyc;
        break;
      end
    end
    tick();
    hif.cmd_valid = 1'b0;
    checks++; if (a5 != a0 + 162) $display("FAIL fifo_accept_on_pop: got cycle %0d required %0d", a5, a0 + 162); else passes++;
    wait_idle(1200);
    ns = 0;
    for (int i = a0 + 1; i < cyc && i < NLOG; i++) begin
      if (op_log[i] !== 32'h0 && op_log[i-1] === 32'h0 && ns < 8) begin
        seq[ns] = op_log[i];
        ns++;
      end
    end
    checks++; if (ns != 6) $display("FAIL fifo_issue_count: got %0d required 6", ns); else passes++;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= ns || seq[k] !== c[k]) $display("FAIL fifo_order_%0d: got %h required %h", k, (k < ns) ? seq[k] : 32'hx, c[k]);
      else passes++;
    end
  endtask

  task automatic test_illegal_opcode();
    int ax, ay;
    logic [31:0] wy;
    wy = 32'h0000_5511;
    push_cmd(32'h0000_0007, ax);
    push_cmd(wy, ay);
    wait_idle(400);
    checks++; if (busy_log[ax+2] !== 1'b1 || op_log[ax+2] !== 32'h0) $display("FAIL ill_issue: got op %h busy %b required op 0 busy 1", op_log[ax+2], busy_log[ax+2]); else passes++;
    checks++; if (op_log[ax+3] !== 32'h0) $display("FAIL ill_gap: got %h required 0", op_log[ax+3]); else passes++;
    checks++; if (op_log[ax+4] !== wy) $display("FAIL ill_next_issue: got %h required %h", op_log[ax+4], wy); else passes++;
  endtask

  task automatic test_reset_mid_read();
    int a, seen, stray;
    push_cmd(32'h0000_0003, a);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      #1;
      if (hif.rd_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++; if (seen == 0) $display("FAIL rm_rd_start: rd_valid=0 after 100 cycles required 1"); else passes++;
    for (int i = 0; i < 10; i++) tick();
    tick();
    reset = 1'b1;
    #1;
    checks++; if (operation !== 32'h0 || hif.rd_valid !== 1'b0) $display("FAIL rm_in_reset: got op %h rd_valid %b required 0 0", operation, hif.rd_valid); else passes++;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (operation !== 32'h0) $display("FAIL rm_operation: got %h required 0", operation); else passes++;
    checks++; if (hif.rd_valid !== 1'b0) $display("FAIL rm_rd_valid: got %b required 0", hif.rd_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b required 0", busy); else passes++;
    stray = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      #1;
      if (hif.rd_valid !== 1'b0 || operation !== 32'h0) stray++;
    end
    checks++; if (stray != 0) $display("FAIL rm_stale: got %0d active cycles required 0", stray); else passes++;
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    hif.cmd_valid = 1'b0;
    hif.cmd_data  = 32'h0;
    hif.wr_valid  = 1'b0;
    hif.wr_data   = 32'h0;
    test_reset();
    test_matmul();
    test_enable_freeze();
    test_write();
    test_read();
    test_fifo_full();
    test_illegal_opcode();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
